// File: rtl/i2c_slave_responder_pkg.sv
// ============================================================================
// Module   : i2c_slave_responder_pkg
// Brief    : Shared states and bus constants for the I2C responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_slave_responder_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_WR_BYTE   = 4'd4,
    ST_WR_ACK    = 4'd5,
    ST_RD_BYTE   = 4'd6,
    ST_RD_ACK    = 4'd7,
    ST_WAIT_STOP = 4'd8
  } state_e;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // Bit-counter landmarks: 8 = data done / drive ACK, 9 = ACK clock seen.
  localparam logic [3:0] BIT_LAST      = 4'd7;
  localparam logic [3:0] BIT_ACK_DRIVE = 4'd8;
  localparam logic [3:0] BIT_ACK_DONE  = 4'd9;

endpackage

`default_nettype wire

// File: rtl/i2c_slave_responder_sync_edge.sv
// ============================================================================
// Module   : i2c_sync_edge
// Brief    : Two-flop synchroniser plus history flop with edge outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level_out,
  output logic rise_out,
  output logic fall_out
);

  // [0] metastable stage, [1] synchronised level, [2] history
  logic [2:0] pipe_q;
  logic [2:0] pipe_d;

  always_comb begin
    pipe_d = {pipe_q[1:0], line_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= {3{RESET_VAL}};
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign level_out = pipe_q[1];
  assign rise_out  = pipe_q[1] & ~pipe_q[2];
  assign fall_out  = ~pipe_q[1] & pipe_q[2];

endmodule

`default_nettype wire

// File: rtl/i2c_slave_responder.sv
// ============================================================================
// Module   : i2c_slave_responder
// Brief    : I2C target with pointer-based register bank and write strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_slave_responder
  import i2c_slave_responder_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         REG_ADDR   = 4
) (
  input  logic                i2c_clock_in,
  input  logic                i2c_reset_in,
  input  logic                scl_in,
  input  logic                sda_in,
  output logic                sda_oe_out,
  output logic                wr_strobe_out,
  output logic [REG_ADDR-1:0] wr_addr_out,
  output logic [7:0]          wr_data_out,
  output logic                busy_out,
  input  logic [REG_ADDR-1:0] reg_rd_addr_in,
  output logic [7:0]          reg_rd_data_out
);

  localparam int                DEPTH   = 1 << REG_ADDR;
  localparam logic [REG_ADDR-1:0] PTR_ONE = REG_ADDR'(1);

  logic w_scl_level, w_scl_rise, w_scl_fall;
  logic w_sda_level, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;
  logic [7:0] w_byte;
  logic [REG_ADDR-1:0] w_ptr_inc;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [REG_ADDR-1:0] ptr_q, ptr_d;
  logic                rw_q, rw_d;
  logic                oe_q, oe_d;
  logic                busy_q, busy_d;
  logic                strobe_q, strobe_d;
  logic [REG_ADDR-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic [7:0]          bank_q [DEPTH];
  logic [7:0]          bank_d [DEPTH];

  i2c_sync_edge u_scl_sync (
    .clk       (i2c_clock_in),
    .rst       (i2c_reset_in),
    .line_in   (scl_in),
    .level_out (w_scl_level),
    .rise_out  (w_scl_rise),
    .fall_out  (w_scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk       (i2c_clock_in),
    .rst       (i2c_reset_in),
    .line_in   (sda_in),
    .level_out (w_sda_level),
    .rise_out  (w_sda_rise),
    .fall_out  (w_sda_fall)
  );

  assign w_start   = w_sda_fall & w_scl_level;
  assign w_stop    = w_sda_rise & w_scl_level;
  assign w_byte    = {shift_q[6:0], w_sda_level};
  assign w_ptr_inc = ptr_q + PTR_ONE;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    strobe_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    bank_d    = bank_q;

    if (w_start) begin
      state_d = ST_ADDR;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
    end else if (w_stop) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (w_scl_rise) begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WR_BYTE: begin
          shift_d = w_byte;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == BIT_LAST) begin
            case (state_q)
              ST_ADDR: begin
                if (w_byte[7:1] == SLAVE_ADDR) begin
                  state_d = ST_ADDR_ACK;
                  busy_d  = 1'b1;
                  rw_d    = w_byte[0];
                end else begin
                  state_d = ST_WAIT_STOP;
                  busy_d  = 1'b0;
                end
              end
              ST_PTR: begin
                ptr_d   = w_byte[REG_ADDR-1:0];
                state_d = ST_WR_ACK;
              end
              default: begin
                bank_d[ptr_q] = w_byte;
                ptr_d         = w_ptr_inc;
                strobe_d      = 1'b1;
                wr_addr_d     = ptr_q;
                wr_data_d     = w_byte;
                state_d       = ST_WR_ACK;
              end
            endcase
          end
        end
        ST_ADDR_ACK, ST_WR_ACK, ST_RD_BYTE: cnt_d = cnt_q + 4'd1;
        ST_RD_ACK: begin
          case (w_sda_level)
            ACK: begin
              ptr_d   = w_ptr_inc;
              shift_d = bank_q[w_ptr_inc];
              state_d = ST_RD_BYTE;
              // Marks "first bit not yet driven" for the coming SCL fall.
              cnt_d   = BIT_ACK_DONE;
            end
            NACK: begin
              state_d = ST_WAIT_STOP;
              busy_d  = 1'b0;
            end
          endcase
        end
        default: ;
      endcase
    end else if (w_scl_fall) begin
      case (state_q)
        ST_ADDR_ACK, ST_WR_ACK: begin
          if (cnt_q == BIT_ACK_DRIVE) begin
            oe_d = 1'b1;
          end else if (cnt_q == BIT_ACK_DONE) begin
            oe_d  = 1'b0;
            cnt_d = 4'd0;
            if (state_q == ST_WR_ACK) begin
              state_d = ST_WR_BYTE;
            end else begin
              case (rw_q)
                RW_WRITE: state_d = ST_PTR;
                RW_READ: begin
                  shift_d = bank_q[ptr_q];
                  oe_d    = ~bank_q[ptr_q][7];
                  state_d = ST_RD_BYTE;
                end
              endcase
            end
          end
        end
        ST_RD_BYTE: begin
          if (cnt_q == BIT_ACK_DRIVE) begin
            oe_d    = 1'b0;
            state_d = ST_RD_ACK;
          end else if (cnt_q == BIT_ACK_DONE) begin
            oe_d  = ~shift_q[7];
            cnt_d = 4'd0;
          end else begin
            shift_d = {shift_q[6:0], 1'b0};
            oe_d    = ~shift_q[6];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i2c_clock_in or posedge i2c_reset_in) begin
    if (i2c_reset_in) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      shift_q   <= 8'd0;
      ptr_q     <= '0;
      rw_q      <= RW_WRITE;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      strobe_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'd0;
      bank_q    <= '{default: 8'd0};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      strobe_q  <= strobe_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      bank_q    <= bank_d;
    end
  end

  assign sda_oe_out      = oe_q;
  assign wr_strobe_out   = strobe_q;
  assign wr_addr_out     = wr_addr_q;
  assign wr_data_out     = wr_data_q;
  assign busy_out        = busy_q;
  assign reg_rd_data_out = bank_q[reg_rd_addr_in];

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_responder.sv
// ============================================================================
// Module   : tb_i2c_slave_responder
// Brief    : Bus-level bench: bit-banged master, register model, strobe scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_slave_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_drv, sda_drv;
  logic       sda_line;
  logic       sda_oe_out, wr_strobe_out, busy_out;
  logic [3:0] wr_addr_out, reg_rd_addr_in;
  logic [7:0] wr_data_out, reg_rd_data_out;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model [16];
  logic [11:0] exp_q [$];
  logic [7:0]  rd_exp_q [$];
  logic [11:0] obs [256];
  int          obs_cnt = 0;
  int          rd_idx  = 0;
  int          oe_cnt  = 0;
  int          busy_cnt = 0;

  always #5 clk = ~clk;

  assign sda_line = sda_drv & ~sda_oe_out;

  i2c_slave_responder #(.SLAVE_ADDR(7'h50), .REG_ADDR(4)) dut (
    .i2c_clock_in    (clk),
    .i2c_reset_in    (rst),
    .scl_in          (scl_drv),
    .sda_in          (sda_line),
    .sda_oe_out      (sda_oe_out),
    .wr_strobe_out   (wr_strobe_out),
    .wr_addr_out     (wr_addr_out),
    .wr_data_out     (wr_data_out),
    .busy_out        (busy_out),
    .reg_rd_addr_in  (reg_rd_addr_in),
    .reg_rd_data_out (reg_rd_data_out)
  );

  // Observed write strobes and sticky activity counters.
  always @(negedge clk) begin
    if (wr_strobe_out && obs_cnt < 256) begin
      obs[obs_cnt] <= {wr_addr_out, wr_data_out};
      obs_cnt      <= obs_cnt + 1;
    end
    if (sda_oe_out) oe_cnt <= oe_cnt + 1;
    if (busy_out) busy_cnt <= busy_cnt + 1;
  end

  task automatic wait_q;
    repeat (8) @(negedge clk);
  endtask

  task automatic bus_start;
    sda_drv = 1'b1; scl_drv = 1'b1; wait_q;
    sda_drv = 1'b0; wait_q;
    scl_drv = 1'b0; wait_q;
  endtask

  task automatic bus_rstart;
    sda_drv = 1'b1; wait_q;
    scl_drv = 1'b1; wait_q;
    sda_drv = 1'b0; wait_q;
    scl_drv = 1'b0; wait_q;
  endtask

  task automatic bus_stop;
    sda_drv = 1'b0; wait_q;
    scl_drv = 1'b1; wait_q;
    sda_drv = 1'b1; wait_q;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sda_drv = b[7-i]; wait_q;
      scl_drv = 1'b1; wait_q; wait_q;
      scl_drv = 1'b0; wait_q;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    sda_drv = 1'b1; wait_q;
    scl_drv = 1'b1; wait_q;
    ack = sda_line; wait_q;
    scl_drv = 1'b0; wait_q;
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic mack);
    sda_drv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_q;
      scl_drv = 1'b1; wait_q;
      d[7-i] = sda_line; wait_q;
      scl_drv = 1'b0;
    end
    sda_drv = mack; wait_q;
    scl_drv = 1'b1; wait_q; wait_q;
    scl_drv = 1'b0; wait_q;
    sda_drv = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1; reg_rd_addr_in = 4'd0;
    for (int i = 0; i < 16; i++) model[i] = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sda_oe_out, wr_strobe_out, busy_out, wr_addr_out, wr_data_out} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got oe=%b stb=%b busy=%b addr=%h data=%h expected all 0",
               sda_oe_out, wr_strobe_out, busy_out, wr_addr_out, wr_data_out);
    end
    rst = 1'b0;
    wait_q;
  endtask

  task automatic test_write;
    logic ack;
    logic [11:0] e;
    bus_start;
    send_byte(8'hA0, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_addr_ack got %b expected 0", ack); end
    checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL wr_busy got %b expected 1", busy_out); end
    send_byte(8'h03, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_ptr_ack got %b expected 0", ack); end
    exp_q.push_back({4'd3, 8'h5A}); model[3] = 8'h5A;
    send_byte(8'h5A, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_d0_ack got %b expected 0", ack); end
    exp_q.push_back({4'd4, 8'hC3}); model[4] = 8'hC3;
    send_byte(8'hC3, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_d1_ack got %b expected 0", ack); end
    bus_stop;
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL wr_busy_stop got %b expected 0", busy_out); end
    checks++;
    if (obs_cnt - rd_idx != exp_q.size()) begin
      errors++; $display("FAIL wr_strobe_count got %0d expected %0d", obs_cnt - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_idx < obs_cnt) begin
        checks++;
        if (obs[rd_idx] !== e) begin errors++; $display("FAIL wr_strobe got %h expected %h", obs[rd_idx], e); end
        rd_idx++;
      end
    end
    rd_idx = obs_cnt;
    for (int a = 3; a <= 4; a++) begin
      reg_rd_addr_in = 4'(a); #1;
      checks++;
      if (reg_rd_data_out !== model[a]) begin
        errors++; $display("FAIL wr_reg%0d got %h expected %h", a, reg_rd_data_out, model[a]);
      end
    end
  endtask

  task automatic test_read;
    logic ack;
    logic [7:0] d, e;
    bus_start;
    send_byte(8'hA0, ack);
    send_byte(8'h03, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_ptr_ack got %b expected 0", ack); end
    bus_rstart;
    send_byte(8'hA1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_addr_ack got %b expected 0", ack); end
    rd_exp_q.push_back(model[3]);
    rd_exp_q.push_back(model[4]);
    recv_byte(d, 1'b0);
    e = rd_exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL rd_byte0 got %h expected %h", d, e); end
    recv_byte(d, 1'b1);
    e = rd_exp_q.pop_front();
    checks++; if (d !== e) begin errors++; $display("FAIL rd_byte1 got %h expected %h", d, e); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL rd_busy_nack got %b expected 0", busy_out); end
    bus_stop;
  endtask

  task automatic test_mismatch;
    logic ack;
    int o0, b0, s0;
    o0 = oe_cnt; b0 = busy_cnt; s0 = obs_cnt;
    bus_start;
    send_byte(8'hA2, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mm_addr_ack got %b expected 1", ack); end
    send_byte(8'h55, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mm_data_ack got %b expected 1", ack); end
    bus_stop;
    checks++; if (oe_cnt !== o0) begin errors++; $display("FAIL mm_oe got %0d cycles expected 0", oe_cnt - o0); end
    checks++; if (busy_cnt !== b0) begin errors++; $display("FAIL mm_busy got %0d cycles expected 0", busy_cnt - b0); end
    checks++; if (obs_cnt !== s0) begin errors++; $display("FAIL mm_strobes got %0d expected 0", obs_cnt - s0); end
    rd_idx = obs_cnt;
  endtask

  task automatic test_wrap;
    logic ack;
    logic [11:0] e;
    bus_start;
    send_byte(8'hA0, ack);
    send_byte(8'h0F, ack);
    exp_q.push_back({4'd15, 8'h11}); model[15] = 8'h11;
    send_byte(8'h11, ack);
    exp_q.push_back({4'd0, 8'h22}); model[0] = 8'h22;
    send_byte(8'h22, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wrap_ack got %b expected 0", ack); end
    bus_stop;
    checks++;
    if (obs_cnt - rd_idx != exp_q.size()) begin
      errors++; $display("FAIL wrap_strobe_count got %0d expected %0d", obs_cnt - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_idx < obs_cnt) begin
        checks++;
        if (obs[rd_idx] !== e) begin errors++; $display("FAIL wrap_strobe got %h expected %h", obs[rd_idx], e); end
        rd_idx++;
      end
    end
    rd_idx = obs_cnt;
    reg_rd_addr_in = 4'd15; #1;
    checks++; if (reg_rd_data_out !== model[15]) begin errors++; $display("FAIL wrap_reg15 got %h expected %h", reg_rd_data_out, model[15]); end
    reg_rd_addr_in = 4'd0; #1;
    checks++; if (reg_rd_data_out !== model[0]) begin errors++; $display("FAIL wrap_reg0 got %h expected %h", reg_rd_data_out, model[0]); end
  endtask

  task automatic test_abort;
    logic ack;
    int s0;
    s0 = obs_cnt;
    bus_start;
    send_byte(8'hA0, ack);
    send_byte(8'h05, ack);
    send_bits(8'hF0, 4);
    bus_stop;
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL abort_busy got %b expected 0", busy_out); end
    checks++; if (obs_cnt !== s0) begin errors++; $display("FAIL abort_strobes got %0d expected 0", obs_cnt - s0); end
    reg_rd_addr_in = 4'd5; #1;
    checks++; if (reg_rd_data_out !== model[5]) begin errors++; $display("FAIL abort_reg5 got %h expected %h", reg_rd_data_out, model[5]); end
    rd_idx = obs_cnt;

    // Reset while the first read bit (MSB of 0x5A = 0) is being driven.
    bus_start;
    send_byte(8'hA0, ack);
    send_byte(8'h03, ack);
    bus_rstart;
    send_byte(8'hA1, ack);
    checks++; if (sda_oe_out !== 1'b1) begin errors++; $display("FAIL rst_pre_oe got %b expected 1", sda_oe_out); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (sda_oe_out !== 1'b0) begin errors++; $display("FAIL rst_async_oe got %b expected 0", sda_oe_out); end
    checks++;
    if ({wr_strobe_out, busy_out, wr_addr_out, wr_data_out} !== 14'd0) begin
      errors++; $display("FAIL rst_outputs got stb=%b busy=%b addr=%h data=%h expected all 0",
                         wr_strobe_out, busy_out, wr_addr_out, wr_data_out);
    end
    for (int i = 0; i < 16; i++) model[i] = 8'd0;
    reg_rd_addr_in = 4'd3; #1;
    checks++; if (reg_rd_data_out !== model[3]) begin errors++; $display("FAIL rst_bank got %h expected %h", reg_rd_data_out, model[3]); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_q;
    bus_stop;
    rd_idx = obs_cnt;
  endtask

  task automatic test_back_to_back;
    logic ack;
    logic [7:0] d, er;
    logic [11:0] e;
    bus_start;
    send_byte(8'hA0, ack);
    send_byte(8'h07, ack);
    exp_q.push_back({4'd7, 8'hE7}); model[7] = 8'hE7;
    send_byte(8'hE7, ack);
    bus_stop;
    bus_start;
    send_byte(8'hA0, ack);
    send_byte(8'h06, ack);
    exp_q.push_back({4'd6, 8'h99}); model[6] = 8'h99;
    send_byte(8'h99, ack);
    send_bits(8'hA0, 3);
    bus_rstart;
    send_byte(8'hA1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rs_addr_ack got %b expected 0", ack); end
    rd_exp_q.push_back(model[7]);
    recv_byte(d, 1'b1);
    er = rd_exp_q.pop_front();
    checks++; if (d !== er) begin errors++; $display("FAIL rs_read got %h expected %h", d, er); end
    bus_stop;
    checks++;
    if (obs_cnt - rd_idx != exp_q.size()) begin
      errors++; $display("FAIL rs_strobe_count got %0d expected %0d", obs_cnt - rd_idx, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_idx < obs_cnt) begin
        checks++;
        if (obs[rd_idx] !== e) begin errors++; $display("FAIL rs_strobe got %h expected %h", obs[rd_idx], e); end
        rd_idx++;
      end
    end
    rd_idx = obs_cnt;
    reg_rd_addr_in = 4'd7; #1;
    checks++; if (reg_rd_data_out !== model[7]) begin errors++; $display("FAIL rs_reg7 got %h expected %h", reg_rd_data_out, model[7]); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_write;
    test_read;
    test_mismatch;
    test_wrap;
    test_abort;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
